// File: rtl/parking_slot_store.sv
// rtl/parking_slot_store.sv - per-bay occupancy, entry-time and exit-cost store with lowest-free allocation
module parking_slot_store #(
    parameter int NUM_SLOTS = 8,
    parameter int SEL_W     = 3,
    parameter int TIME_W    = 10,
    parameter int COST_W    = 10,
    parameter int RATE      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TIME_W-1:0]   cur_time,
    input  logic                park_req,
    input  logic                exit_req,
    input  logic [SEL_W-1:0]    exit_slot,
    output logic                park_ack,
    output logic                park_fail,
    output logic [SEL_W-1:0]    park_slot,
    output logic                exit_ack,
    output logic                exit_err,
    output logic [COST_W-1:0]   exit_cost,
    output logic                busy,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [TIME_W-1:0]   rd_entry_time,
    output logic [COST_W-1:0]   rd_cost,
    output logic                rd_occupied,
    output logic [SEL_W:0]      occ_count,
    output logic                full,
    output logic                empty
);

    typedef enum logic [1:0] {IDLE, ALLOC, BILL} state_t;

    localparam int              PROD_W     = TIME_W + 32;
    localparam logic [SEL_W:0]  SLOT_LIMIT = (SEL_W+1)'(NUM_SLOTS);

    state_t                 state;
    logic [TIME_W-1:0]      entry_time [NUM_SLOTS];
    logic [COST_W-1:0]      cost       [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   occupied;
    logic [TIME_W-1:0]      lat_time;
    logic [SEL_W-1:0]       lat_slot;

    logic                   free_found;
    logic [SEL_W-1:0]       free_idx;
    logic                   bill_ok;
    logic [TIME_W-1:0]      duration;
    logic [PROD_W-1:0]      product;
    logic [COST_W-1:0]      bill_cost;
    logic                   rd_ok;

    // Descending scan so the last hit, the lowest free index, wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                free_found = 1'b1;
                free_idx   = SEL_W'(i);
            end
        end
    end

    // Modular subtraction makes a wrapped timer come out right.
    always_comb begin
        bill_ok  = 1'b0;
        duration = '0;
        if ({1'b0, lat_slot} < SLOT_LIMIT) begin
            bill_ok  = occupied[lat_slot];
            duration = lat_time - entry_time[lat_slot];
        end
        product   = PROD_W'(duration) * PROD_W'(RATE);
        bill_cost = (|product[PROD_W-1:COST_W]) ? {COST_W{1'b1}} : product[COST_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            occupied  <= '0;
            lat_time  <= '0;
            lat_slot  <= '0;
            occ_count <= '0;
            park_ack  <= 1'b0;
            park_fail <= 1'b0;
            park_slot <= '0;
            exit_ack  <= 1'b0;
            exit_err  <= 1'b0;
            exit_cost <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                entry_time[i] <= '0;
                cost[i]       <= '0;
            end
        end else begin
            park_ack  <= 1'b0;
            park_fail <= 1'b0;
            exit_ack  <= 1'b0;
            exit_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (exit_req) begin
                        lat_slot <= exit_slot;
                        lat_time <= cur_time;
                        state    <= BILL;
                    end else if (park_req) begin
                        lat_time <= cur_time;
                        state    <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (free_found) begin
                        entry_time[free_idx] <= lat_time;
                        cost[free_idx]       <= '0;
                        occupied[free_idx]   <= 1'b1;
                        occ_count            <= occ_count + 1'b1;
                        park_slot            <= free_idx;
                        park_ack             <= 1'b1;
                    end else begin
                        park_fail <= 1'b1;
                    end
                    state <= IDLE;
                end
                BILL: begin
                    if (bill_ok) begin
                        cost[lat_slot]     <= bill_cost;
                        occupied[lat_slot] <= 1'b0;
                        occ_count          <= occ_count - 1'b1;
                        exit_cost          <= bill_cost;
                        exit_ack           <= 1'b1;
                    end else begin
                        exit_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign full  = (occ_count == SLOT_LIMIT);
    assign empty = (occ_count == '0);

    assign rd_ok         = ({1'b0, rd_sel} < SLOT_LIMIT);
    assign rd_entry_time = rd_ok ? entry_time[rd_sel] : '0;
    assign rd_cost       = rd_ok ? cost[rd_sel] : '0;
    assign rd_occupied   = rd_ok ? occupied[rd_sel] : 1'b0;

endmodule

// File: tb/tb_parking_slot_store.sv
// tb/tb_parking_slot_store.sv - randomized and directed bench against a behavioural bay model
module tb_parking_slot_store;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [9:0] cur_time;
    logic       park_req, exit_req;
    logic [2:0] exit_slot, rd_sel;
    logic       park_ack, park_fail, exit_ack, exit_err, busy, rd_occupied, full, empty;
    logic [2:0] park_slot;
    logic [9:0] exit_cost, rd_entry_time, rd_cost;
    logic [3:0] occ_count;

    logic       p6, e6, pa6, pf6, ea6, ee6, b6, ro6, f6, em6;
    logic [2:0] es6, rs6, ps6;
    logic [9:0] ec6, re6, rc6;
    logic [3:0] oc6;

    parking_slot_store dut (
        .clk(clk), .reset(reset), .cur_time(cur_time), .park_req(park_req), .exit_req(exit_req),
        .exit_slot(exit_slot), .park_ack(park_ack), .park_fail(park_fail), .park_slot(park_slot),
        .exit_ack(exit_ack), .exit_err(exit_err), .exit_cost(exit_cost), .busy(busy),
        .rd_sel(rd_sel), .rd_entry_time(rd_entry_time), .rd_cost(rd_cost), .rd_occupied(rd_occupied),
        .occ_count(occ_count), .full(full), .empty(empty));

    parking_slot_store #(.NUM_SLOTS(6)) dut6 (
        .clk(clk), .reset(reset), .cur_time(cur_time), .park_req(p6), .exit_req(e6),
        .exit_slot(es6), .park_ack(pa6), .park_fail(pf6), .park_slot(ps6),
        .exit_ack(ea6), .exit_err(ee6), .exit_cost(ec6), .busy(b6),
        .rd_sel(rs6), .rd_entry_time(re6), .rd_cost(rc6), .rd_occupied(ro6),
        .occ_count(oc6), .full(f6), .empty(em6));

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;
    bit rd_rand = 1'b0;

    bit         m_occ [NS];
    logic [9:0] m_entry [NS];
    logic [9:0] m_cost [NS];
    logic [2:0] m_park_slot;
    logic [9:0] m_exit_cost;
    bit         e_pa, e_pf, e_ea, e_ee, e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_occ[i] = 1'b0; m_entry[i] = '0; m_cost[i] = '0;
        end
        m_park_slot = '0; m_exit_cost = '0;
        e_pa = 0; e_pf = 0; e_ea = 0; e_ee = 0; e_busy = 0;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NS; i++) c += int'(m_occ[i]);
        return c;
    endfunction

    task automatic model_apply(input bit pr, input bit er, input logic [2:0] s, input logic [9:0] t);
        int dur, prod, c, f;
        if (er) begin
            if (!m_occ[s]) e_ee = 1;
            else begin
                dur  = (int'(t) - int'(m_entry[s]) + 1024) % 1024;
                prod = dur * 2;
                c    = (prod > 1023) ? 1023 : prod;
                m_cost[s] = 10'(c); m_occ[s] = 0; m_exit_cost = 10'(c); e_ea = 1;
            end
        end else if (pr) begin
            f = -1;
            for (int i = NS - 1; i >= 0; i--) if (!m_occ[i]) f = i;
            if (f < 0) e_pf = 1;
            else begin
                m_occ[f] = 1; m_entry[f] = t; m_cost[f] = '0; m_park_slot = 3'(f); e_pa = 1;
            end
        end
    endtask

    // Request at E0, result visible after E1; returns at E1 + 1.
    task automatic op(input bit pr, input bit er, input logic [2:0] s, input logic [9:0] t);
        @(negedge clk);
        park_req = pr; exit_req = er; exit_slot = s; cur_time = t;
        @(posedge clk); #1;
        park_req = 0; exit_req = 0;
        e_pa = 0; e_pf = 0; e_ea = 0; e_ee = 0; e_busy = pr | er;
        @(posedge clk); #1;
        e_busy = 0;
        model_apply(pr, er, s, t);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        e_pa = 0; e_pf = 0; e_ea = 0; e_ee = 0;
    endtask

    task automatic op6(input bit pr, input bit er, input logic [2:0] s);
        @(negedge clk);
        p6 = pr; e6 = er; es6 = s;
        @(posedge clk); #1;
        p6 = 0; e6 = 0;
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        #2;
        if (rd_rand) rd_sel = 3'($urandom_range(0, 7));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, e_busy);
            chk("park_ack", park_ack, e_pa);
            chk("park_fail", park_fail, e_pf);
            chk("exit_ack", exit_ack, e_ea);
            chk("exit_err", exit_err, e_ee);
            chk("park_slot", park_slot, m_park_slot);
            chk("exit_cost", exit_cost, m_exit_cost);
            chk("occ_count", occ_count, m_count());
            chk("full", full, m_count() == NS);
            chk("empty", empty, m_count() == 0);
            chk("rd_entry_time", rd_entry_time, m_entry[rd_sel]);
            chk("rd_cost", rd_cost, m_cost[rd_sel]);
            chk("rd_occupied", rd_occupied, m_occ[rd_sel]);
        end
    end

    initial begin
        logic [9:0] t;
        bit pr, er;
        reset = 0; cur_time = 0; park_req = 0; exit_req = 0; exit_slot = 0; rd_sel = 0;
        p6 = 0; e6 = 0; es6 = 0; rs6 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1;
        for (int i = 0; i < NS; i++) begin
            rd_sel = 3'(i); #1;
            chk("rst_rd_entry", rd_entry_time, 0);
            chk("rst_rd_cost", rd_cost, 0);
            chk("rst_rd_occ", rd_occupied, 0);
        end
        chk("rst_occ_count", occ_count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {park_ack, park_fail, exit_ack, exit_err}, 0);
        chk_en = 1; rd_rand = 1;

        op(1, 0, 0, 10'h123);
        rd_rand = 0; rd_sel = 0; #1;
        chk("park0_slot", park_slot, 0);
        chk("park0_entry", rd_entry_time, 10'h123);
        chk("park0_occ", rd_occupied, 1);
        chk("park0_count", occ_count, 1);
        rd_rand = 1;

        op(1, 0, 0, 10'h3F0);
        op(0, 1, 1, 10'h010);
        rd_rand = 0; rd_sel = 1; #1;
        chk("wrap_exit_cost", exit_cost, 10'h040);
        chk("wrap_rd_cost", rd_cost, 10'h040);
        chk("wrap_rd_occ", rd_occupied, 0);
        rd_rand = 1;
        op(1, 0, 0, 10'h000);
        chk("reuse_slot1", park_slot, 1);
        op(0, 1, 1, 10'h300);
        chk("sat_exit_cost", exit_cost, 10'h3FF);

        op(0, 1, 5, 10'h100);
        chk("empty_bay_err", exit_err, 1);
        chk("empty_bay_count", occ_count, 1);

        for (int i = 1; i < NS; i++) begin
            op(1, 0, 0, 10'(i * 37));
            chk("fill_slot", park_slot, i);
        end
        chk("fill_full", full, 1);
        op(1, 0, 0, 10'h055);
        chk("full_park_fail", park_fail, 1);
        chk("full_count", occ_count, 8);
        op(0, 1, 3, 10'h200);
        op(1, 0, 0, 10'h210);
        chk("refill_slot3", park_slot, 3);

        op(1, 1, 0, 10'h220);
        chk("both_exit_ack", exit_ack, 1);
        chk("both_no_park", park_ack, 0);
        chk("both_count", occ_count, 7);
        idle();

        t = 10'h000;
        repeat (400) begin
            pr = 1'($urandom_range(0, 3) != 0);
            er = 1'($urandom_range(0, 1));
            t  = t + 10'($urandom_range(0, 700));
            op(pr, er, 3'($urandom_range(0, 7)), t);
            if ($urandom_range(0, 3) == 0) idle();
        end

        op(1, 0, 0, 10'h0AA);
        @(negedge clk);
        park_req = 1; cur_time = 10'h1BB;
        @(posedge clk); #1;
        park_req = 0; chk_en = 0; reset = 0; #1;
        chk("async_busy", busy, 0);
        chk("async_pulses", {park_ack, park_fail, exit_ack, exit_err}, 0);
        chk("async_count", occ_count, 0);
        chk("async_empty", empty, 1);
        chk("async_park_slot", park_slot, 0);
        chk("async_exit_cost", exit_cost, 0);
        model_reset();
        @(posedge clk); #1;
        chk("async_hold_ack", park_ack, 0);
        @(negedge clk) reset = 1;
        rd_rand = 0;
        for (int i = 0; i < NS; i++) begin
            rd_sel = 3'(i); #1;
            chk("async_rd_occ", rd_occupied, 0);
        end
        rd_rand = 1; chk_en = 1;
        repeat (3) idle();

        cur_time = 10'h155;
        op6(0, 1, 7);
        chk("n6_bad_slot_err", ee6, 1);
        chk("n6_bad_slot_count", oc6, 0);
        for (int i = 0; i < 6; i++) begin
            op6(1, 0, 0);
            chk("n6_park_ack", pa6, 1);
            chk("n6_park_slot", ps6, i);
        end
        chk("n6_full", f6, 1);
        op6(1, 0, 0);
        chk("n6_park_fail", pf6, 1);
        op6(0, 1, 7);
        chk("n6_full_bad_err", ee6, 1);
        chk("n6_full_count", oc6, 6);
        rs6 = 0; #1;
        chk("n6_rd0_entry", re6, 10'h155);
        rs6 = 7; #1;
        chk("n6_rd7_entry", re6, 0);
        chk("n6_rd7_occ", ro6, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
